// File: rtl/core_pkg.sv
// Shared definitions for the PC/next-PC datapath: branch encodings, default
// vectors and the next-PC source selector.
package core_pkg;

    localparam logic [2:0] BT_BEQ  = 3'b000;
    localparam logic [2:0] BT_BNE  = 3'b001;
    localparam logic [2:0] BT_BLT  = 3'b100;
    localparam logic [2:0] BT_BGE  = 3'b101;
    localparam logic [2:0] BT_BLTU = 3'b110;
    localparam logic [2:0] BT_BGEU = 3'b111;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_BRANCH,
        SRC_JAL,
        SRC_JALR,
        SRC_TRAP,
        SRC_MRET
    } pc_src_e;

    // The ALU already picks signed/unsigned compare, so blt/bltu and
    // bge/bgeu share one condition each.
    function automatic logic branch_cond(input logic [2:0] bt,
                                         input logic zero,
                                         input logic less);
        logic c;
        c = 1'b0;
        case (bt)
            BT_BEQ:            c = zero;
            BT_BNE:            c = !zero;
            BT_BLT, BT_BLTU:   c = less;
            BT_BGE, BT_BGEU:   c = !less;
            default:           c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the core controller and the PC unit.
interface pc_unit_if #(
    parameter int XLEN      = 32,
    parameter int EPC_DEPTH = 4
);
    localparam int DW = $clog2(EPC_DEPTH) + 1;

    logic            stall;
    logic            branch;
    logic [2:0]      branch_type;
    logic            zero;
    logic            less;
    logic            jump;
    logic            jalr;
    logic [XLEN-1:0] imm32;
    logic [XLEN-1:0] alu_result;
    logic            trap;
    logic            mret;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            taken;
    logic            misaligned;
    logic [DW-1:0]   epc_depth;
    logic            epc_overflow;
    logic            epc_underflow;

    modport master (
        output stall, branch, branch_type, zero, less, jump, jalr,
               imm32, alu_result, trap, mret,
        input  pc, pc_plus4, taken, misaligned, epc_depth,
               epc_overflow, epc_underflow
    );

    modport slave (
        input  stall, branch, branch_type, zero, less, jump, jalr,
               imm32, alu_result, trap, mret,
        output pc, pc_plus4, taken, misaligned, epc_depth,
               epc_overflow, epc_underflow
    );

endinterface

// File: rtl/pc_unit_epc_stack.sv
// Circular LIFO of saved trap PCs; a push when full overwrites the oldest entry.
module epc_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    top_idx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mem [DEPTH];

    // ptr is the next write slot; wrapping it onto the oldest entry gives the
    // overwrite-oldest behaviour for free because DEPTH is a power of two.
    assign top_idx = ptr - PW'(1);
    assign top     = mem[top_idx];
    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (!full) begin
                cnt <= cnt + CW'(1);
            end
        end else if (pop && !empty) begin
            ptr <= top_idx;
            cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= din;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with next-PC resolution for branch/JAL/JALR/trap/mret and a
// nested-trap saved-PC stack.
module pc_unit
    import core_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC),
    parameter int              EPC_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    pc_unit_if.slave   bus
);
    localparam int DW = $clog2(EPC_DEPTH) + 1;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4_c;
    logic [XLEN-1:0] rel_tgt;
    logic [XLEN-1:0] jalr_tgt;
    logic [XLEN-1:0] jump_tgt;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] stack_top;
    pc_src_e         src;
    logic            misaligned_c;
    logic            push;
    logic            pop;
    logic            unf_set;
    logic            stk_full;
    logic            stk_empty;
    logic [DW-1:0]   stk_count;
    logic            ovf_q;
    logic            unf_q;

    assign pc_plus4_c = pc_q + XLEN'(4);
    assign rel_tgt    = pc_q + (bus.imm32 << 1);
    assign jalr_tgt   = bus.alu_result & ~XLEN'(1);

    always_comb begin
        src = SRC_SEQ;
        if (bus.trap) begin
            src = SRC_TRAP;
        end else if (bus.mret) begin
            src = SRC_MRET;
        end else if (bus.jump && bus.jalr) begin
            src = SRC_JALR;
        end else if (bus.jump) begin
            src = SRC_JAL;
        end else if (bus.branch && branch_cond(bus.branch_type, bus.zero, bus.less)) begin
            src = SRC_BRANCH;
        end
    end

    assign jump_tgt     = (src == SRC_JALR) ? jalr_tgt : rel_tgt;
    assign misaligned_c = (src inside {SRC_JALR, SRC_JAL, SRC_BRANCH}) &&
                          (jump_tgt[1:0] != 2'b00);

    // A misaligned jump target is never loaded; it becomes a trap that saves
    // the faulting pc. mret on an empty stack falls through to pc+4.
    always_comb begin
        next_pc = pc_plus4_c;
        push    = 1'b0;
        pop     = 1'b0;
        unf_set = 1'b0;
        if (src == SRC_TRAP || misaligned_c) begin
            next_pc = TRAP_VEC;
            push    = 1'b1;
        end else begin
            case (src)
                SRC_MRET: begin
                    if (!stk_empty) begin
                        next_pc = stack_top;
                        pop     = 1'b1;
                    end else begin
                        unf_set = 1'b1;
                    end
                end
                SRC_JALR, SRC_JAL, SRC_BRANCH: next_pc = jump_tgt;
                default: next_pc = pc_plus4_c;
            endcase
        end
    end

    epc_stack #(
        .WIDTH (XLEN),
        .DEPTH (EPC_DEPTH),
        .CW    (DW)
    ) u_epc_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push && !bus.stall),
        .pop   (pop && !bus.stall),
        .din   (pc_q),
        .top   (stack_top),
        .full  (stk_full),
        .empty (stk_empty),
        .count (stk_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_VEC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (!bus.stall) begin
            pc_q <= next_pc;
            if (push && stk_full) begin
                ovf_q <= 1'b1;
            end
            if (unf_set) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus4      = pc_plus4_c;
    assign bus.taken         = (next_pc != pc_plus4_c);
    assign bus.misaligned    = misaligned_c;
    assign bus.epc_depth     = stk_count;
    assign bus.epc_overflow  = ovf_q;
    assign bus.epc_underflow = unf_q;

endmodule
